// File: rtl/btn_evt_pkg.sv
// Shared definitions for the button gesture classifier and its consumers.
package btn_evt_pkg;

  // Gesture FSM state encodings.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    REL1   = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_e;

  // Event indices used by the LED/counter consumers when packing pulses.
  localparam int EVT_SHORT = 0;
  localparam int EVT_LONG  = 1;
  localparam int EVT_DBL   = 2;
  localparam int EVT_RPT   = 3;
  localparam int EVT_NUM   = 4;

  // Largest of three timing parameters; sizes the shared counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/btn_evt_sig_edge.sv
// Edge detector for a level that is already synchronous to clk.
// RST_VAL sets what the previous level is assumed to be out of reset; 1 means
// an input held high across reset does not produce a rise.
module sig_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic prev_q;

  // Remember the level from the previous clock.
  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= RST_VAL;
    else        prev_q <= sig_i;
  end

  assign rise_o = sig_i & ~prev_q;
  assign fall_o = ~sig_i & prev_q;

endmodule

// File: rtl/btn_evt.sv
// Press-gesture classifier: turns a debounced button level into single-cycle
// short / long / double / repeat pulses plus a busy level.
module btn_evt
  import btn_evt_pkg::*;
#(
  parameter int LONG_CLKS = 1000,
  parameter int DBL_CLKS  = 300,
  parameter int RPT_CLKS  = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_short,
  output logic o_long,
  output logic o_dbl,
  output logic o_rpt,
  output logic o_busy
);

  localparam int CNT_W = $clog2(max3(LONG_CLKS, DBL_CLKS, RPT_CLKS));

  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'(LONG_CLKS - 1);
  localparam logic [CNT_W-1:0] DBL_M1  = CNT_W'(DBL_CLKS - 1);
  localparam logic [CNT_W-1:0] RPT_M1  = CNT_W'(RPT_CLKS - 1);

  logic rise, fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             dbl_q, dbl_d;
  logic             rpt_q, rpt_d;
  logic             busy_q, busy_d;
  logic             cnt_run, cnt_clr;

  sig_edge #(
    .RST_VAL(1'b1)
  ) u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_i (i_sig),
    .rise_o(rise),
    .fall_o(fall)
  );

  // Next-state, counter and event decisions for the gesture FSM.
  always_comb begin
    state_d = state_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
    rpt_d   = 1'b0;
    cnt_run = 1'b0;
    cnt_clr = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rise) state_d = PRESS1;
      end
      PRESS1: begin
        cnt_run = 1'b1;
        // A release in the same cycle as the long threshold is still a short press.
        if (fall) begin
          state_d = REL1;
        end else if (cnt_q == LONG_M1) begin
          long_d  = 1'b1;
          state_d = LONG;
        end
      end
      REL1: begin
        cnt_run = 1'b1;
        // A second press on the last cycle of the window still counts as double.
        if (rise) begin
          dbl_d   = 1'b1;
          state_d = PRESS2;
        end else if (cnt_q == DBL_M1) begin
          short_d = 1'b1;
          state_d = IDLE;
        end
      end
      PRESS2: begin
        if (fall) state_d = IDLE;
      end
      LONG: begin
        cnt_run = 1'b1;
        if (fall) begin
          state_d = IDLE;
        end else if (cnt_q == RPT_M1) begin
          rpt_d   = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // One counter shared by all timed states; restart on every state change.
    if ((state_d != state_q) || cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_run && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    busy_d = (state_d != IDLE);
  end

  // State, counter and registered event outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      rpt_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      rpt_q   <= rpt_d;
      busy_q  <= busy_d;
    end
  end

  assign o_short = short_q;
  assign o_long  = long_q;
  assign o_dbl   = dbl_q;
  assign o_rpt   = rpt_q;
  assign o_busy  = busy_q;

endmodule
